// File: rtl/reg_file_2r1w.sv
// MIPS-32 register file: two combinational read ports, one synchronous write port,
// a never-bypassed debug read port, and a count of committed writes.
module reg_file_2r1w #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int BYPASS     = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_rs_addr,
  input  logic [ADDR_WIDTH-1:0] i_rt_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data1,
  output logic [DATA_WIDTH-1:0] o_rd_data2,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
  output logic [DATA_WIDTH-1:0] o_dbg_data,
  output logic [15:0]           o_wr_count
);

  localparam bit LP_BYPASS = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];
  logic [15:0]           r_wr_count;
  logic                  w_commit;

  // A write to $0 is dropped entirely, so it neither stores nor counts.
  assign w_commit = i_wr_en && (i_wr_addr != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem      <= '{default: '0};
      r_wr_count <= '0;
    end else if (w_commit) begin
      r_mem[i_wr_addr] <= i_wr_data;
      r_wr_count       <= r_wr_count + 16'd1;
    end
  end

  always_comb begin
    o_rd_data1 = '0;
    o_rd_data2 = '0;
    o_dbg_data = '0;
    // Reset masks every read; address 0 reads 0 even when a bypass would match.
    if (!i_rst) begin
      if (i_rs_addr != '0) begin
        if (LP_BYPASS && w_commit && (i_wr_addr == i_rs_addr))
          o_rd_data1 = i_wr_data;
        else
          o_rd_data1 = r_mem[i_rs_addr];
      end
      if (i_rt_addr != '0) begin
        if (LP_BYPASS && w_commit && (i_wr_addr == i_rt_addr))
          o_rd_data2 = i_wr_data;
        else
          o_rd_data2 = r_mem[i_rt_addr];
      end
      if (i_dbg_addr != '0)
        o_dbg_data = r_mem[i_dbg_addr];
    end
  end

  assign o_wr_count = r_wr_count;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: one bypassing and one non-bypassing instance
// share the same stimulus, with hand-computed expectations for each.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrEn;
  logic [4:0]  wrAddr, rsAddr, rtAddr, dbgAddr;
  logic [31:0] wrData;

  logic [31:0] bRd1, bRd2, bDbg, nRd1, nRd2, nDbg;
  logic [15:0] bCnt, nCnt;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  reg_file_2r1w #(.BYPASS(1)) dutB (
    .i_clk(clk), .i_rst(rst),
    .i_rs_addr(rsAddr), .i_rt_addr(rtAddr),
    .o_rd_data1(bRd1), .o_rd_data2(bRd2),
    .i_wr_en(wrEn), .i_wr_addr(wrAddr), .i_wr_data(wrData),
    .i_dbg_addr(dbgAddr), .o_dbg_data(bDbg), .o_wr_count(bCnt)
  );

  reg_file_2r1w #(.BYPASS(0)) dutN (
    .i_clk(clk), .i_rst(rst),
    .i_rs_addr(rsAddr), .i_rt_addr(rtAddr),
    .o_rd_data1(nRd1), .o_rd_data2(nRd2),
    .i_wr_en(wrEn), .i_wr_addr(wrAddr), .i_wr_data(wrData),
    .i_dbg_addr(dbgAddr), .o_dbg_data(nDbg), .o_wr_count(nCnt)
  );

  task automatic applyStimulus(input logic r, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] dbg);
    rst = r; wrEn = we; wrAddr = wa; wrData = wd;
    rsAddr = rs; rtAddr = rt; dbgAddr = dbg;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [4:0]  lastAddr, prevAddr;
    logic [31:0] lastData, prevData;
    lastAddr = '0; prevAddr = '0; lastData = '0; prevData = '0;

    // Initial reset
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("init_rd1_in_rst", bRd1, 32'h0);
    checkOutput("init_count", {16'h0, bCnt}, 32'h0);

    // Reset clear: $5 written, then reset with a pending write to $7
    applyStimulus(0, 1, 5, 32'hDEADBEEF, 5, 0, 5);
    checkOutput("wr5_bypass_rd1", bRd1, 32'hDEADBEEF);
    checkOutput("wr5_nobypass_rd1", nRd1, 32'h0);
    tick();
    checkOutput("wr5_dbg", bDbg, 32'hDEADBEEF);
    checkOutput("wr5_count", {16'h0, bCnt}, 32'd1);
    applyStimulus(1, 1, 7, 32'h1234, 5, 7, 5);
    checkOutput("rst_rd1_forced", bRd1, 32'h0);
    checkOutput("rst_rd2_bypass_masked", bRd2, 32'h0);
    checkOutput("rst_dbg_forced", nDbg, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 5, 7, 5);
    checkOutput("post_rst_r5", nRd1, 32'h0);
    checkOutput("post_rst_r7", nRd2, 32'h0);
    checkOutput("post_rst_dbg5", bDbg, 32'h0);
    checkOutput("post_rst_count", {16'h0, bCnt}, 32'd0);

    // Basic write/read
    applyStimulus(0, 1, 8, 32'h0000_00FF, 0, 0, 0);
    tick();
    applyStimulus(0, 1, 9, 32'hFFFF_FF00, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 8, 9, 9);
    checkOutput("basic_b_rd1", bRd1, 32'h0000_00FF);
    checkOutput("basic_b_rd2", bRd2, 32'hFFFF_FF00);
    checkOutput("basic_n_rd1", nRd1, 32'h0000_00FF);
    checkOutput("basic_n_rd2", nRd2, 32'hFFFF_FF00);
    checkOutput("basic_dbg9", nDbg, 32'hFFFF_FF00);
    checkOutput("basic_count", {16'h0, bCnt}, 32'd2);

    // $0 protection
    applyStimulus(0, 1, 0, 32'hAAAA_AAAA, 0, 0, 0);
    checkOutput("r0_same_b_rd1", bRd1, 32'h0);
    checkOutput("r0_same_b_rd2", bRd2, 32'h0);
    checkOutput("r0_same_dbg", bDbg, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("r0_next_b_rd1", bRd1, 32'h0);
    checkOutput("r0_next_n_rd1", nRd1, 32'h0);
    checkOutput("r0_next_dbg", nDbg, 32'h0);
    checkOutput("r0_count", {16'h0, nCnt}, 32'd2);

    // Bypass on both ports at once
    applyStimulus(0, 1, 12, 32'h7, 0, 0, 0);
    tick();
    applyStimulus(0, 1, 12, 32'h5555_0001, 12, 12, 12);
    checkOutput("byp_b_rd1", bRd1, 32'h5555_0001);
    checkOutput("byp_b_rd2", bRd2, 32'h5555_0001);
    checkOutput("byp_b_dbg_old", bDbg, 32'h7);
    checkOutput("byp_n_rd1_old", nRd1, 32'h7);
    checkOutput("byp_n_rd2_old", nRd2, 32'h7);
    tick();
    applyStimulus(0, 0, 0, 0, 12, 12, 12);
    checkOutput("byp_n_rd1_new", nRd1, 32'h5555_0001);
    checkOutput("byp_dbg_new", nDbg, 32'h5555_0001);
    checkOutput("byp_count", {16'h0, bCnt}, 32'd4);

    // Bypass on one port only
    applyStimulus(0, 1, 8, 32'h11, 12, 8, 8);
    checkOutput("byp1_b_rd1", bRd1, 32'h5555_0001);
    checkOutput("byp1_b_rd2", bRd2, 32'h11);
    checkOutput("byp1_n_rd2", nRd2, 32'hFF);
    checkOutput("byp1_dbg", bDbg, 32'hFF);
    tick();

    // wr_en low leaves the register and count untouched
    applyStimulus(0, 1, 3, 32'h33, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 3, 32'h99, 3, 3, 3);
    checkOutput("wroff_same_b_rd1", bRd1, 32'h33);
    tick();
    applyStimulus(0, 0, 0, 0, 3, 3, 3);
    checkOutput("wroff_n_rd1", nRd1, 32'h33);
    checkOutput("wroff_dbg", bDbg, 32'h33);
    checkOutput("wroff_count", {16'h0, bCnt}, 32'd6);

    // Counter wrap: reset, then 65536 commits to addresses 1..31
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 0; i < 65536; i++) begin
      prevAddr = lastAddr;
      prevData = lastData;
      lastAddr = 5'((i % 31) + 1);
      lastData = {16'hC0DE, 16'(i)};
      if (i == 65535)
        checkOutput("wrap_pre_count", {16'h0, bCnt}, 32'h0000_FFFF);
      applyStimulus(0, 1, lastAddr, lastData, 0, 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, prevAddr, lastAddr, lastAddr);
    checkOutput("wrap_b_count", {16'h0, bCnt}, 32'h0);
    checkOutput("wrap_n_count", {16'h0, nCnt}, 32'h0);
    checkOutput("wrap_last_dbg", bDbg, 32'hC0DE_FFFF);
    checkOutput("wrap_last_rd2", nRd2, lastData);
    checkOutput("wrap_prev_rd1", nRd1, 32'hC0DE_FFFE);
    checkOutput("wrap_prev_data", prevData, 32'hC0DE_FFFE);

    // One more commit after the wrap
    applyStimulus(0, 1, 31, 32'h1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_plus1_count", {16'h0, bCnt}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- MIPS-32 general-purpose register file: 32 x 32-bit, two combinational read ports (rs, rt), one synchronous write port.
- The write port consumes the destination address from the upstream rt/rd destination selector, together with RegWrite and write-back data.
- Read ports feed the ALU operand path. A third read-only debug port gives the bench and top-level visibility of register contents.
- Register $0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, number of registers (must equal 2**ADDR_WIDTH)
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = reads return stored value only

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- rs_addr  in  ADDR_WIDTH  read port 1 address (instr[25:21])
- rt_addr  in  ADDR_WIDTH  read port 2 address (instr[20:16])
- rd_data1  out  DATA_WIDTH  read port 1 data
- rd_data2  out  DATA_WIDTH  read port 2 data
- wr_en  in  1  RegWrite from control
- wr_addr  in  ADDR_WIDTH  destination register, from the rt/rd destination selector
- wr_data  in  DATA_WIDTH  write-back data (ALU result or memory load)
- dbg_addr  in  ADDR_WIDTH  debug read address
- dbg_data  out  DATA_WIDTH  debug read data, combinational, never bypassed
- wr_count  out  16  count of committed writes, wraps at 0xFFFF -> 0

Behaviour:
- Reset, sampled at a rising edge with rst=1:
  - all NUM_REGS entries cleared to 0
  - wr_count cleared to 0
  - a wr_en in the same cycle is ignored
- While rst=1: rd_data1, rd_data2 and dbg_data are forced to 0 combinationally, independent of addresses and stored state.
- Write commit:
  - on a rising edge with rst=0, wr_en=1 and wr_addr!=0: mem[wr_addr] <= wr_data, and wr_count increments by 1.
  - Latency: the value is visible on the non-bypassed read paths from the next cycle.
- Writes to $0:
  - wr_en=1 with wr_addr=0 is silently discarded; mem[0] stays 0.
  - wr_count does NOT increment.
- Reads:
  - combinational, zero-cycle latency.
  - addr=0 always returns 0, including under bypass.
- Bypass (BYPASS=1):
  - if wr_en=1, rst=0 and wr_addr==rs_addr!=0, then rd_data1=wr_data in the same cycle. Same rule for rt_addr/rd_data2.
  - both ports may bypass simultaneously when rs_addr==rt_addr==wr_addr.
- BYPASS=0: reads return the stored value; the new value appears after the edge.
- dbg_data: mem[dbg_addr], never bypassed, 0 for dbg_addr=0.
- wr_count arithmetic: unsigned 16-bit; 0xFFFF plus one commit gives 0x0000; no saturation.
- Reset mid-operation: a reset edge overrides any pending write. The next cycle after rst deasserts behaves as fresh (all reads 0).
- No X propagation: every output is defined from the first reset edge onward.

Test Plan:
- Reset clear: write $5=0xDEADBEEF, assert rst one cycle with wr_en=1, wr_addr=7, wr_data=0x1234 -> next cycle $5=0, $7=0, wr_count=0; rd_data1=0 while rst=1.
- Basic write/read: write $8=0x0000_00FF, then $9=0xFFFF_FF00 -> rs_addr=8, rt_addr=9 give 0x0000_00FF / 0xFFFF_FF00; wr_count=2.
- $0 protection: wr_en=1, wr_addr=0, wr_data=0xAAAA_AAAA -> rd_data1 with rs_addr=0 reads 0 in the same cycle and next cycle; dbg_data(0)=0; wr_count unchanged.
- Bypass: BYPASS=1, wr_en=1, wr_addr=rs_addr=rt_addr=12, wr_data=0x5555_0001, $12 previously 0x7 -> both read ports show 0x5555_0001 in the same cycle, and dbg_data(12)=0x7 until the edge. With BYPASS=0 -> both ports show 0x7 until the edge.
- wr_en low: wr_en=0, wr_addr=3, wr_data=0x99 -> $3 unchanged after the edge; wr_count unchanged.
- Counter wrap: perform 65536 commits to rotating addresses 1..31 -> wr_count reads 0x0000; the last write is readable via dbg_addr.
